dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter: INDEX_BITS, 8, line-index field width; address splits as tag[31:13], index[12:5], byte offset[4:0].
REQ-002 clk  input  1  clock; all state changes on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req / cpu_we  input  1/1  request valid / write (1) or read (0).
REQ-005 cpu_addr / cpu_wdata  input  32/32  byte address (bits[1:0] ignored) / write word.
REQ-006 cpu_byte_en  input  4  write byte enables; bit 3 = byte at lowest address.
REQ-007 cpu_ready / cpu_rdata  output  1/32  one-cycle completion pulse / read word.
REQ-008 line_enable, line_compare, line_read  output  1 each  line-store control; line_read=0 means line write.
REQ-009 line_addr / line_data_line_in  output  32/256  line-store address / full line to write.
REQ-010 line_set_valid / line_set_dirty  output  1/1  valid and dirty bits written with a line write.
REQ-011 line_hit, line_valid, line_dirty  input  1 each  line-store status, valid the cycle after a read.
REQ-012 line_data_out / line_data_line_out / line_tag_out  input  32/256/32  word, whole line, stored tag (low 19 bits used).
REQ-013 mem_req / mem_we  output  1/1  memory request / write-back (1) or refill (0).
REQ-014 mem_addr / mem_wdata  output  32/256  line-aligned address (bits[4:0]=0) / write-back line.
REQ-015 mem_ready / mem_rdata  input  1/256  one-cycle transfer-done pulse / refill line, valid with mem_ready.

Function
REQ-016 Byte order is big-endian: byte offset k occupies line bits [255-8k : 248-8k]; word at offset w=addr[4:2] occupies bits [255-32w : 224-32w].
REQ-017 FSM states: IDLE, CHECK, WBACK, REFILL, INSTALL, RESP.
REQ-018 IDLE: cpu_req=1 -> latch addr/we/byte_en/wdata, drive line_enable=1, line_compare=1, line_read=1, line_addr=cpu_addr; next CHECK. cpu_req=0 -> all line and mem outputs 0.
REQ-019 CHECK, line_valid & line_hit & read -> load cpu_rdata from line_data_out; next RESP.
REQ-020 CHECK, line_valid & line_hit & write -> line write of line_data_line_out merged with wdata per byte_en, set_valid=1, set_dirty=1, cpu_rdata unchanged; next RESP.
REQ-021 CHECK, miss with line_valid & line_dirty -> capture line_data_line_out; next WBACK. Any other miss -> next REFILL.
REQ-022 WBACK: mem_req=1, mem_we=1, mem_addr={line_tag_out[18:0], latched index, 5'b0}, mem_wdata=captured line; held until mem_ready, then next REFILL.
REQ-023 REFILL: mem_req=1, mem_we=0, mem_addr={latched addr[31:5], 5'b0}; on mem_ready capture mem_rdata, next INSTALL.
REQ-024 INSTALL: line write of refill line (merged with wdata per byte_en if write), set_valid=1, set_dirty=latched we; cpu_rdata loaded with selected word of merged line; next RESP.
REQ-025 RESP: cpu_ready=1 exactly one cycle; next IDLE. cpu_rdata held until next load.
REQ-026 Latency: read/write hit = cpu_ready 2 cycles after the cpu_req-sampling edge; miss adds memory wait cycles plus one (clean) or two-stage (dirty).
REQ-027 cpu_req outside IDLE is ignored; CPU holds request fields stable until cpu_ready.
REQ-028 mem_ready while mem_req=0 is ignored; mem_req never drops before mem_ready.
REQ-029 Write with cpu_byte_en=4'b0000 completes normally and sets dirty with data unchanged.
REQ-030 Back-to-back requests: request re-sampled in IDLE the cycle after RESP, no earlier.

Reset
REQ-031 rst=0 asynchronously forces IDLE; cpu_ready, mem_req, mem_we, line_enable=0; cpu_rdata, mem_addr, mem_wdata, line_data_line_in=0.
REQ-032 Reset mid-WBACK/REFILL abandons the transfer; no line write is issued and no cpu_ready follows.

Verification
REQ-033 Read hit: line valid, tag match, word 0x11223344 at offset 8 -> cpu_rdata=0x11223344, cpu_ready 2 cycles after request.
REQ-034 Write hit 0xAABBCCDD, byte_en=4'b1010 at addr 0x4 over 0x11223344 -> line word becomes 0xAA22CC44, set_dirty=1.
REQ-035 Read miss, invalid line, addr 0x0000_2024 -> mem_addr=0x0000_2020, mem_we=0; after mem_ready install with set_dirty=0, cpu_rdata = refill word 1.
REQ-036 Miss on dirty line with tag 0x00001, index 0x01 -> WBACK mem_addr=0x0000_2020, mem_we=1, then REFILL; 3 stall cycles on each mem_ready -> cpu_ready exactly once.
REQ-037 rst=0 asserted during REFILL -> mem_req=0 immediately, IDLE, no line write, no cpu_ready.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped data cache controller: sequences line-store lookups, write-back of
// dirty victims and refills from memory, with big-endian byte merging of CPU writes.
module dcache_ctrl #(
    parameter int INDEX_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    input  logic [3:0]   cpu_byte_en,
    output logic         cpu_ready,
    output logic [31:0]  cpu_rdata,
    output logic         line_enable,
    output logic         line_compare,
    output logic         line_read,
    output logic [31:0]  line_addr,
    output logic [255:0] line_data_line_in,
    output logic         line_set_valid,
    output logic         line_set_dirty,
    input  logic         line_hit,
    input  logic         line_valid,
    input  logic         line_dirty,
    input  logic [31:0]  line_data_out,
    input  logic [255:0] line_data_line_out,
    input  logic [31:0]  line_tag_out,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [255:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [255:0] mem_rdata
);

    localparam int TAG_BITS = 27 - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WBACK,
        REFILL,
        INSTALL,
        RESP
    } state_t;

    state_t state, state_next;

    logic [31:2]         addr_q;
    logic                we_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic [255:0]        line_q;
    logic [TAG_BITS-1:0] tag_q;
    logic [31:0]         rdata_q;

    logic [255:0] merge_src;
    logic [255:0] merged;
    logic [7:0]   word_base;
    logic [31:0]  sel_word;
    logic         unused_tag_bits;

    // Word w sits at bits [255-32w -: 32]; byte-enable bit i maps to word bits [8i +: 8].
    function automatic logic [255:0] merge_line(input logic [255:0] line,
                                                input logic [2:0]   word,
                                                input logic [31:0]  data,
                                                input logic [3:0]   be);
        logic [255:0] res;
        logic [7:0]   pos;
        logic [4:0]   dpos;
        res = line;
        for (int i = 0; i < 4; i++) begin
            pos  = {~word, 5'b0} + {3'b0, i[1:0], 3'b0};
            dpos = {i[1:0], 3'b0};
            if (be[i]) res[pos +: 8] = data[dpos +: 8];
        end
        return res;
    endfunction

    assign unused_tag_bits = ^line_tag_out[31:TAG_BITS];

    // A read install merges nothing, so the same path serves hits and installs.
    assign merge_src = (state == CHECK) ? line_data_line_out : line_q;
    assign merged    = merge_line(merge_src, addr_q[4:2], wdata_q, we_q ? be_q : 4'b0000);
    assign word_base = {~addr_q[4:2], 5'b0};
    assign sel_word  = merged[word_base +: 32];
    assign cpu_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            line_q  <= '0;
            tag_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr[31:2];
                        we_q    <= cpu_we;
                        be_q    <= cpu_byte_en;
                        wdata_q <= cpu_wdata;
                    end
                end
                CHECK: begin
                    if (line_valid && line_hit) begin
                        if (!we_q) rdata_q <= line_data_out;
                    end else if (line_valid && line_dirty) begin
                        line_q <= line_data_line_out;
                        tag_q  <= line_tag_out[TAG_BITS-1:0];
                    end
                end
                REFILL: begin
                    if (mem_ready) line_q <= mem_rdata;
                end
                INSTALL: rdata_q <= sel_word;
                default: ;
            endcase
        end
    end

    // Outputs are gated by reset so nothing leaks while rst is low, even with cpu_req high.
    always_comb begin
        state_next        = state;
        cpu_ready         = 1'b0;
        line_enable       = 1'b0;
        line_compare      = 1'b0;
        line_read         = 1'b0;
        line_addr         = '0;
        line_data_line_in = '0;
        line_set_valid    = 1'b0;
        line_set_dirty    = 1'b0;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        line_enable  = 1'b1;
                        line_compare = 1'b1;
                        line_read    = 1'b1;
                        line_addr    = cpu_addr;
                        state_next   = CHECK;
                    end
                end
                CHECK: begin
                    if (line_valid && line_hit) begin
                        if (we_q) begin
                            line_enable       = 1'b1;
                            line_addr         = {addr_q, 2'b00};
                            line_data_line_in = merged;
                            line_set_valid    = 1'b1;
                            line_set_dirty    = 1'b1;
                        end
                        state_next = RESP;
                    end else if (line_valid && line_dirty) begin
                        state_next = WBACK;
                    end else begin
                        state_next = REFILL;
                    end
                end
                WBACK: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {tag_q, addr_q[INDEX_BITS+4:5], 5'b0};
                    mem_wdata = line_q;
                    if (mem_ready) state_next = REFILL;
                end
                REFILL: begin
                    mem_req  = 1'b1;
                    mem_addr = {addr_q[31:5], 5'b0};
                    if (mem_ready) state_next = INSTALL;
                end
                INSTALL: begin
                    line_enable       = 1'b1;
                    line_addr         = {addr_q, 2'b00};
                    line_data_line_in = merged;
                    line_set_valid    = 1'b1;
                    line_set_dirty    = we_q;
                    state_next        = RESP;
                end
                RESP: begin
                    cpu_ready  = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus queues expected CPU responses, line writes
// and memory transfers; a negedge monitor pops and compares whenever the DUT presents one.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_we;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic [3:0]   cpu_byte_en;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         line_enable, line_compare, line_read;
    logic [31:0]  line_addr;
    logic [255:0] line_data_line_in;
    logic         line_set_valid, line_set_dirty;
    logic         line_hit, line_valid, line_dirty;
    logic [31:0]  line_data_out;
    logic [255:0] line_data_line_out;
    logic [31:0]  line_tag_out;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_ready;
    logic [255:0] mem_rdata;

    typedef struct { logic [31:0] rdata; int lat; int req_cyc; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [255:0] wdata; } memx_t;
    typedef struct { logic [31:0] addr; logic [255:0] data; logic v; logic d; } linex_t;

    resp_t  resp_q[$];
    memx_t  mem_q[$];
    linex_t lw_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_count = 0;

    localparam logic [255:0] L2  = {32'h01010101, 32'h11223344, 32'h03030303, 32'h04040404,
                                    32'h05050505, 32'h06060606, 32'h07070707, 32'h08080808};
    localparam logic [255:0] L2W = {32'h01010101, 32'hAA22CC44, 32'h03030303, 32'h04040404,
                                    32'h05050505, 32'h06060606, 32'h07070707, 32'h08080808};
    localparam logic [255:0] R1  = {32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
                                    32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007};
    localparam logic [255:0] V   = {32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3,
                                    32'hD4D4D4D4, 32'hD5D5D5D5, 32'hD6D6D6D6, 32'hD7D7D7D7};
    localparam logic [255:0] R2  = {32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3,
                                    32'hB4B4B4B4, 32'hB5B5B5B5, 32'hB6B6B6B6, 32'hB7B7B7B7};
    localparam logic [255:0] R2M = {32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB26677B2, 32'hB3B3B3B3,
                                    32'hB4B4B4B4, 32'hB5B5B5B5, 32'hB6B6B6B6, 32'hB7B7B7B7};

    dcache_ctrl #(.INDEX_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byte_en(cpu_byte_en), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .line_enable(line_enable), .line_compare(line_compare), .line_read(line_read),
        .line_addr(line_addr), .line_data_line_in(line_data_line_in),
        .line_set_valid(line_set_valid), .line_set_dirty(line_set_dirty),
        .line_hit(line_hit), .line_valid(line_valid), .line_dirty(line_dirty),
        .line_data_out(line_data_out), .line_data_line_out(line_data_line_out),
        .line_tag_out(line_tag_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT-presented event must match the head of its expectation queue.
    always @(negedge clk) begin
        resp_t  r;
        memx_t  m;
        linex_t l;
        if (rst) begin
            if (cpu_ready) begin
                ready_count++;
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_ready: got cpu_ready=1 expected 0");
                end else begin
                    r = resp_q.pop_front();
                    check_output("cpu_rdata", 256'(cpu_rdata), 256'(r.rdata));
                    check_output("latency", 256'(cyc - r.req_cyc + 1), 256'(r.lat));
                end
            end
            if (line_enable && !line_read) begin
                if (lw_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_line_write: got addr %0h expected none", line_addr);
                end else begin
                    l = lw_q.pop_front();
                    check_output("line_addr", 256'(line_addr), 256'(l.addr));
                    check_output("line_data", line_data_line_in, l.data);
                    check_output("line_set_valid", 256'(line_set_valid), 256'(l.v));
                    check_output("line_set_dirty", 256'(line_set_dirty), 256'(l.d));
                end
            end
            if (mem_req && mem_ready) begin
                if (mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_mem: got addr %0h expected none", mem_addr);
                end else begin
                    m = mem_q.pop_front();
                    check_output("mem_we", 256'(mem_we), 256'(m.we));
                    check_output("mem_addr", 256'(mem_addr), 256'(m.addr));
                    if (m.we) check_output("mem_wdata", mem_wdata, m.wdata);
                end
            end
        end
    end

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [255:0] wdata);
        memx_t m;
        m.we = we; m.addr = addr; m.wdata = wdata;
        mem_q.push_back(m);
    endtask

    task automatic push_line(input logic [31:0] addr, input logic [255:0] data, input logic d);
        linex_t l;
        l.addr = addr; l.data = data; l.v = 1'b1; l.d = d;
        lw_q.push_back(l);
    endtask

    // Called at posedge+1 in IDLE; the next posedge samples the request.
    task automatic apply_stimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                  input logic [3:0] be, input logic [31:0] exp_rdata, input int lat);
        resp_t r;
        cpu_addr = addr; cpu_we = we; cpu_wdata = wdata; cpu_byte_en = be; cpu_req = 1'b1;
        #1;
        check_output("idle_line_enable", 256'(line_enable), 256'(1));
        check_output("idle_line_compare", 256'(line_compare), 256'(1));
        check_output("idle_line_read", 256'(line_read), 256'(1));
        check_output("idle_line_addr", 256'(line_addr), 256'(addr));
        r.rdata = exp_rdata; r.lat = lat; r.req_cyc = cyc + 1;
        resp_q.push_back(r);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic wait_mem_req();
        for (int i = 0; i < 50; i++) begin
            if (mem_req) break;
            @(posedge clk); #1;
        end
        check_output("mem_req_seen", 256'(mem_req), 256'(1));
    endtask

    task automatic mem_respond(input int stalls, input logic [255:0] rdata);
        wait_mem_req();
        repeat (stalls) begin @(posedge clk); #1; end
        mem_ready = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = '0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_ready) break;
        end
        check_output("ready_seen", 256'(cpu_ready), 256'(1));
        @(negedge clk);
        check_output("ready_one_cycle", 256'(cpu_ready), 256'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rc;
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1234_5678;
        cpu_wdata = '0; cpu_byte_en = '0; mem_ready = 1'b0; mem_rdata = '0;
        line_hit = 1'b0; line_valid = 1'b0; line_dirty = 1'b0; line_data_out = '0;
        line_data_line_out = '0; line_tag_out = '0;
        #2 rst = 1'b0;
        #10;
        check_output("rst_cpu_ready", 256'(cpu_ready), 256'(0));
        check_output("rst_mem_req", 256'(mem_req), 256'(0));
        check_output("rst_mem_we", 256'(mem_we), 256'(0));
        check_output("rst_line_enable", 256'(line_enable), 256'(0));
        check_output("rst_cpu_rdata", 256'(cpu_rdata), 256'(0));
        check_output("rst_mem_addr", 256'(mem_addr), 256'(0));
        check_output("rst_mem_wdata", mem_wdata, 256'(0));
        check_output("rst_line_data", line_data_line_in, 256'(0));
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_output("idle_noreq_line_enable", 256'(line_enable), 256'(0));
        check_output("idle_noreq_mem_req", 256'(mem_req), 256'(0));
        @(posedge clk); #1;

        $display("[TB] read hit");
        line_valid = 1'b1; line_hit = 1'b1; line_dirty = 1'b0;
        line_data_out = 32'h11223344; line_data_line_out = L2;
        apply_stimulus(32'h0000_0008, 1'b0, 32'h0, 4'b0000, 32'h11223344, 2);
        wait_ready();

        $display("[TB] write hit with partial byte enables");
        push_line(32'h0000_0004, L2W, 1'b1);
        apply_stimulus(32'h0000_0004, 1'b1, 32'hAABBCCDD, 4'b1010, 32'h11223344, 2);
        wait_ready();

        $display("[TB] write hit with no byte enables");
        push_line(32'h0000_001C, L2, 1'b1);
        apply_stimulus(32'h0000_001C, 1'b1, 32'hDEADBEEF, 4'b0000, 32'h11223344, 2);
        wait_ready();

        $display("[TB] read miss on invalid line");
        line_valid = 1'b0; line_hit = 1'b1; line_dirty = 1'b1;
        push_mem(1'b0, 32'h0000_2020, '0);
        push_line(32'h0000_2024, R1, 1'b0);
        apply_stimulus(32'h0000_2024, 1'b0, 32'h0, 4'b0000, 32'hC0DE0001, 6);
        mem_respond(2, R1);
        wait_ready();

        $display("[TB] write miss on dirty victim");
        line_valid = 1'b1; line_hit = 1'b0; line_dirty = 1'b1;
        line_tag_out = 32'hABC8_0001; line_data_line_out = V;
        push_mem(1'b1, 32'h0000_2020, V);
        push_mem(1'b0, 32'h0000_4020, '0);
        push_line(32'h0000_4028, R2M, 1'b1);
        apply_stimulus(32'h0000_4028, 1'b1, 32'h55667788, 4'b0110, 32'hB26677B2, 11);
        mem_respond(3, '0);
        mem_respond(3, R2);
        wait_ready();

        $display("[TB] reset during refill");
        line_valid = 1'b0; line_hit = 1'b0; line_dirty = 1'b0;
        rc = ready_count;
        cpu_addr = 32'h0000_6040; cpu_we = 1'b0; cpu_req = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        wait_mem_req();
        check_output("refill_addr", 256'(mem_addr), 256'(32'h0000_6040));
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check_output("abort_mem_req", 256'(mem_req), 256'(0));
        check_output("abort_mem_addr", 256'(mem_addr), 256'(0));
        check_output("abort_line_enable", 256'(line_enable), 256'(0));
        check_output("abort_cpu_rdata", 256'(cpu_rdata), 256'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b1; mem_rdata = R2;
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (4) begin @(posedge clk); #1; end
        check_output("abort_no_ready", 256'(ready_count), 256'(rc));
        check_output("abort_idle_mem_req", 256'(mem_req), 256'(0));

        $display("[TB] back-to-back read hits after reset");
        line_valid = 1'b1; line_hit = 1'b1;
        line_data_out = 32'hCAFEF00D;
        apply_stimulus(32'h0000_001C, 1'b0, 32'h0, 4'b0000, 32'hCAFEF00D, 2);
        wait_ready();
        line_data_out = 32'h0BADCAFE;
        apply_stimulus(32'h0000_0010, 1'b0, 32'h0, 4'b0000, 32'h0BADCAFE, 2);
        wait_ready();

        repeat (2) @(posedge clk);
        check_output("resp_queue_drained", 256'(resp_q.size()), 256'(0));
        check_output("mem_queue_drained", 256'(mem_q.size()), 256'(0));
        check_output("line_queue_drained", 256'(lw_q.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
